// File: rtl/pccard_cfg_ctrl.sv
// PC Card 16-bit front end: serves CIS from a synchronous ROM, holds COR/CCSR/SCR,
// gates and strobes the I/O window into the function core and drives cc_ireq.
module pccard_cfg_ctrl #(
    parameter int          CIS_AW      = 8,
    parameter logic [25:0] CFG_BASE    = 26'h200,
    parameter int          IO_AW       = 5,
    parameter int          PULSE_WIDTH = 8,
    parameter int          SRESET_HOLD = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [25:0]       addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              data_oe,
    input  logic              cc_reg,
    input  logic              cc_iord,
    input  logic              cc_iowr,
    input  logic              cc_oe,
    input  logic              cc_we,
    input  logic              cc_ce1,
    input  logic              cc_ce2,
    output logic              cc_ireq,
    output logic [CIS_AW-1:0] cis_addr,
    input  logic [7:0]        cis_data,
    input  logic              card_int,
    output logic              func_reset,
    output logic              io_active,
    output logic [IO_AW-1:0]  io_addr,
    output logic [15:0]       io_wdata,
    output logic              io_rd_stb,
    output logic              io_wr_stb,
    input  logic [15:0]       io_rdata
);

    localparam int PW = $clog2(PULSE_WIDTH + 1);
    localparam int SW = $clog2(SRESET_HOLD + 1);

    typedef enum logic [2:0] {RK_CIS, RK_ZERO, RK_COR, RK_CCSR, RK_SCR} rkind_e;

    logic              oe_q, we_q, iord_q, iowr_q, int_q;
    logic [7:0]        cor_q, cor_d, scr_q, scr_d;
    logic              pwrdwn_q, pwrdwn_d, intr_q, intr_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [SW-1:0]     scnt_q, scnt_d;
    logic              fr_q, fr_d, ireq_q, ireq_d;
    logic              rd1_q, rd2_q, iord2_q;
    rkind_e            kind, kind1_q, kind2_q;
    logic [15:0]       dout_q, dout_d, rd_val;
    logic              doe_q, doe_d, src_io_q, src_io_d;
    logic [CIS_AW-1:0] cis_addr_q;
    logic [IO_AW-1:0]  io_addr_q;
    logic [15:0]       io_wdata_q;
    logic              io_rd_q, io_wr_q;

    logic sel, attr_rd, attr_wr, io_rd, io_wr, io_ok, gate, int_rise, srst_wr;
    logic is_cor, is_ccsr, is_scr, hold;
    logic [7:0] ccsr_rd;

    assign sel      = cc_reg & (cc_ce1 | cc_ce2);
    assign attr_rd  = sel & cc_oe & ~oe_q;
    assign attr_wr  = sel & cc_we & ~we_q;
    assign io_active = |cor_q[5:0];
    // Attribute accesses take priority; an I/O strobe in the same cycle is dropped.
    assign io_ok    = io_active & ~fr_q & ~attr_rd & ~attr_wr;
    assign io_rd    = sel & cc_iord & ~iord_q & io_ok;
    assign io_wr    = sel & cc_iowr & ~iowr_q & io_ok;
    assign gate     = io_active & ~fr_q;
    assign int_rise = card_int & ~int_q;

    assign is_cor  = (addr == CFG_BASE);
    assign is_ccsr = (addr == CFG_BASE + 26'd2);
    assign is_scr  = (addr == CFG_BASE + 26'd4);
    assign srst_wr = attr_wr & is_cor & data_in[7];
    assign ccsr_rd = {5'b0, pwrdwn_q, (cor_q[6] ? int_q : intr_q), 1'b0};

    always_comb begin
        kind = RK_CIS;
        if (addr[0])      kind = RK_ZERO;
        else if (is_cor)  kind = RK_COR;
        else if (is_ccsr) kind = RK_CCSR;
        else if (is_scr)  kind = RK_SCR;
    end

    always_comb begin
        cor_d    = cor_q;
        scr_d    = scr_q;
        pwrdwn_d = pwrdwn_q;
        intr_d   = intr_q;
        if (attr_wr) begin
            if (is_cor) begin
                cor_d = data_in[7:0];
                if (data_in[7]) begin
                    cor_d    = 8'h80;
                    scr_d    = 8'h00;
                    pwrdwn_d = 1'b0;
                    intr_d   = 1'b0;
                end
            end else if (is_ccsr) begin
                pwrdwn_d = data_in[2];
                if (data_in[1]) intr_d = 1'b0;
            end else if (is_scr) begin
                scr_d = data_in[7:0];
            end
        end
        // Set beats a same-cycle clear of the sticky Intr bit.
        if (~cor_q[6] & int_rise & ~fr_q & ~srst_wr) intr_d = 1'b1;

        pcnt_d = pcnt_q;
        if (srst_wr || cor_d[6] || !gate) pcnt_d = '0;
        else if (int_rise && pcnt_q == '0) pcnt_d = PW'(PULSE_WIDTH);
        else if (pcnt_q != '0)             pcnt_d = pcnt_q - 1'b1;
        ireq_d = gate & ~srst_wr & (cor_d[6] ? card_int : (pcnt_d != '0));

        scnt_d = scnt_q;
        if (cor_d[7])           scnt_d = SW'(SRESET_HOLD);
        else if (scnt_q != '0)  scnt_d = scnt_q - 1'b1;
        fr_d = cor_d[7] | (scnt_q != '0);
    end

    always_comb begin
        case (kind2_q)
            RK_CIS:  rd_val = {8'h00, cis_data};
            RK_COR:  rd_val = {8'h00, cor_q};
            RK_CCSR: rd_val = {8'h00, ccsr_rd};
            RK_SCR:  rd_val = {8'h00, scr_q};
            default: rd_val = 16'h0000;
        endcase
        hold     = src_io_q ? cc_iord : cc_oe;
        dout_d   = dout_q;
        doe_d    = doe_q;
        src_io_d = src_io_q;
        if (rd2_q) begin
            dout_d = rd_val;  doe_d = 1'b1; src_io_d = 1'b0;
        end else if (iord2_q) begin
            dout_d = io_rdata; doe_d = 1'b1; src_io_d = 1'b1;
        end else if (doe_q && !hold) begin
            dout_d = 16'h0000; doe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oe_q <= 1'b0; we_q <= 1'b0; iord_q <= 1'b0; iowr_q <= 1'b0; int_q <= 1'b0;
            cor_q <= '0; scr_q <= '0; pwrdwn_q <= 1'b0; intr_q <= 1'b0;
            pcnt_q <= '0; scnt_q <= SW'(SRESET_HOLD); fr_q <= 1'b1; ireq_q <= 1'b0;
            rd1_q <= 1'b0; rd2_q <= 1'b0; iord2_q <= 1'b0;
            kind1_q <= RK_CIS; kind2_q <= RK_CIS;
            dout_q <= '0; doe_q <= 1'b0; src_io_q <= 1'b0;
            cis_addr_q <= '0; io_addr_q <= '0; io_wdata_q <= '0;
            io_rd_q <= 1'b0; io_wr_q <= 1'b0;
        end else begin
            oe_q <= cc_oe; we_q <= cc_we; iord_q <= cc_iord; iowr_q <= cc_iowr; int_q <= card_int;
            cor_q <= cor_d; scr_q <= scr_d; pwrdwn_q <= pwrdwn_d; intr_q <= intr_d;
            pcnt_q <= pcnt_d; scnt_q <= scnt_d; fr_q <= fr_d; ireq_q <= ireq_d;
            rd1_q <= attr_rd; rd2_q <= rd1_q; iord2_q <= io_rd_q;
            kind1_q <= kind; kind2_q <= kind1_q;
            dout_q <= dout_d; doe_q <= doe_d; src_io_q <= src_io_d;
            if (attr_rd) cis_addr_q <= addr[CIS_AW:1];
            if (io_rd | io_wr) begin
                io_addr_q  <= addr[IO_AW-1:0];
                io_wdata_q <= data_in;
            end
            io_rd_q <= io_rd; io_wr_q <= io_wr;
        end
    end

    assign data_out   = dout_q;
    assign data_oe    = doe_q;
    assign cc_ireq    = ireq_q;
    assign cis_addr   = cis_addr_q;
    assign func_reset = fr_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;
    assign io_rd_stb  = io_rd_q;
    assign io_wr_stb  = io_wr_q;

endmodule
